// File: rtl/ula_pkg.sv
// Shared types and widths for the ULA operation sequencer and its helpers.
package ula_pkg;

    localparam int unsigned ULA_IN_W  = 8;
    localparam int unsigned ULA_OUT_W = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } ula_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_DONE   = 2'b10
    } seq_state_t;

    // Settle-counter width: clog2 of the larger settle time, never below one bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/settle_counter.sv
// Loadable down-counter that stops at zero; also intended for the multiplier pipeline.
module settle_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic         is_zero
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= value;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign is_zero = (count_q == '0);

endmodule

// File: rtl/ula_op_sequencer.sv
// Holds operands at the ULA for a per-op settle time, then registers result and flags.
// Define ULA_SEQ_DIV_ZERO_EN to intercept DIV with a zero divisor before the divider is used.
module ula_op_sequencer
    import ula_pkg::*;
#(
    parameter int unsigned DIV_SETTLE = 4,
    parameter int unsigned ALU_SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ULA_IN_W-1:0]  in_a,
    input  logic [ULA_IN_W-1:0]  in_b,
    input  logic [1:0]           in_op,
    output logic [ULA_IN_W-1:0]  ula_a,
    output logic [ULA_IN_W-1:0]  ula_b,
    output logic [1:0]           ula_op,
    input  logic [ULA_OUT_W-1:0] ula_result,
    input  logic                 ula_sign_flag,
    input  logic                 ula_zero_flag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ULA_OUT_W-1:0] out_result,
    output logic                 out_sign_flag,
    output logic                 out_zero_flag,
    output logic                 out_div_zero
);

    localparam int unsigned CNT_W = cnt_width(DIV_SETTLE, ALU_SETTLE);

    seq_state_t           state_q;
    logic [ULA_IN_W-1:0]  ula_a_q;
    logic [ULA_IN_W-1:0]  ula_b_q;
    logic [1:0]           ula_op_q;
    logic [ULA_OUT_W-1:0] result_q;
    logic                 sign_q;
    logic                 zero_q;
    logic                 valid_q;

    logic             accept;
    logic             div_zero_hit;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_value;

    // DONE accepts alongside the result handoff so back-to-back ops skip the IDLE bubble.
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign cnt_load  = accept && !div_zero_hit;
    assign cnt_dec   = (state_q == ST_SETTLE);
    assign cnt_value = (ula_op_t'(in_op) == OP_DIV) ? CNT_W'(DIV_SETTLE - 1)
                                                    : CNT_W'(ALU_SETTLE - 1);

    settle_counter #(
        .W(CNT_W)
    ) u_settle_counter (
        .clk     (clk),
        .reset   (reset),
        .load    (cnt_load),
        .value   (cnt_value),
        .dec     (cnt_dec),
        .is_zero (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ula_a_q  <= '0;
            ula_b_q  <= '0;
            ula_op_q <= '0;
            result_q <= '0;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (cnt_zero) begin
                        result_q <= ula_result;
                        sign_q   <= ula_sign_flag;
                        zero_q   <= ula_zero_flag;
                        valid_q  <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: ;
            endcase

            // An accept (from IDLE or DONE) overrides the state-specific updates above.
            if (accept) begin
                ula_a_q  <= in_a;
                ula_b_q  <= in_b;
                ula_op_q <= in_op;
                if (div_zero_hit) begin
                    result_q <= '0;
                    sign_q   <= 1'b0;
                    zero_q   <= 1'b1;
                    valid_q  <= 1'b1;
                    state_q  <= ST_DONE;
                end else begin
                    state_q  <= ST_SETTLE;
                end
            end
        end
    end

`ifdef ULA_SEQ_DIV_ZERO_EN
    logic div_zero_q;

    assign div_zero_hit = (ula_op_t'(in_op) == OP_DIV) && (in_b == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_zero_q <= 1'b0;
        end else if (accept && div_zero_hit) begin
            div_zero_q <= 1'b1;
        end else if ((state_q == ST_SETTLE) && cnt_zero) begin
            div_zero_q <= 1'b0;
        end
    end

    assign out_div_zero = div_zero_q;
`else
    assign div_zero_hit = 1'b0;
    assign out_div_zero = 1'b0;
`endif

    assign ula_a         = ula_a_q;
    assign ula_b         = ula_b_q;
    assign ula_op        = ula_op_q;
    assign out_valid     = valid_q;
    assign out_result    = result_q;
    assign out_sign_flag = sign_q;
    assign out_zero_flag = zero_q;

endmodule
